// File: rtl/obstacle_scheduler.sv
// Frame-rate obstacle slot scheduler: spawns, scrolls and retires obstacles under gamemode control.
// Optional difficulty ramp enabled by defining OBSTACLE_DIFFICULTY_RAMP_EN.
module obstacle_scheduler #(
  parameter int          SLOTS          = 10,
  parameter int          SCREEN_W       = 640,
  parameter int          OBS_W          = 40,
  parameter int          OBS_H          = 120,
  parameter int          UPPER_BOUND    = 20,
  parameter int          LOWER_BOUND    = 460,
  parameter int          SPAWN_INTERVAL = 90,
  parameter int          SCROLL_SPEED   = 4,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_gamemode,
  output logic [SLOTS-1:0][9:0] o_obstacle_x_left,
  output logic [SLOTS-1:0][9:0] o_obstacle_x_right,
  output logic [SLOTS-1:0][8:0] o_obstacle_y_up,
  output logic [SLOTS-1:0][8:0] o_obstacle_y_down,
  output logic [SLOTS-1:0]      o_active,
  output logic                  o_spawn_overflow,
  output logic [15:0]           o_passed_count
);

  localparam int CNT_W   = $clog2(SPAWN_INTERVAL + 1);
  localparam int RCNT_W  = $clog2(SLOTS + 1);
  localparam int Y_RANGE = LOWER_BOUND - UPPER_BOUND - OBS_H;

  typedef enum logic [1:0] {
    S_CLEAR = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SLOTS-1:0][9:0] r_x_left, r_x_right;
  logic [SLOTS-1:0][8:0] r_y_up, r_y_down;
  logic [SLOTS-1:0]      r_active;
  logic                  r_overflow;
  logic [15:0]           r_passed;
  logic [15:0]           r_lfsr;
  logic [CNT_W-1:0]      r_cnt;

  logic [3:0]        w_speed;
  logic [CNT_W-1:0]  w_reload;
  logic [SLOTS-1:0]  w_retire, w_spawn_sel;
  logic [RCNT_W-1:0] w_retire_cnt;
  logic [16:0]       w_passed_sum;
  logic              w_spawn_due, w_free_found, w_lfsr_fb;
  logic [8:0]        w_r_raw, w_r_adj, w_y_up;

`ifdef OBSTACLE_DIFFICULTY_RAMP_EN
  logic [9:0]       r_frame;
  logic [3:0]       r_speed;
  logic [CNT_W-1:0] r_interval;
  assign w_speed  = r_speed;
  assign w_reload = r_interval - CNT_W'(1);
`else
  assign w_speed  = 4'(SCROLL_SPEED);
  assign w_reload = CNT_W'(SPAWN_INTERVAL - 1);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_CLEAR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = state_t'(i_gamemode);
  end

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_r_raw   = r_lfsr[8:0];
  assign w_r_adj   = (w_r_raw >= 9'(Y_RANGE)) ? w_r_raw - 9'(Y_RANGE) : w_r_raw;
  assign w_y_up    = 9'(UPPER_BOUND) + w_r_adj;

  assign w_spawn_due  = (r_cnt == '0);
  assign w_free_found = |(~r_active);
  // lowest clear bit of the active mask; all-ones wraps to zero so nothing is selected
  assign w_spawn_sel  = w_spawn_due ? (~r_active & (r_active + SLOTS'(1))) : '0;

  always_comb begin
    w_retire     = '0;
    w_retire_cnt = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (r_active[i] && (r_x_right[i] <= {6'd0, w_speed})) begin
        w_retire[i]  = 1'b1;
        w_retire_cnt = w_retire_cnt + RCNT_W'(1);
      end
    end
    w_passed_sum = {1'b0, r_passed} + 17'(w_retire_cnt);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x_left   <= '0;
      r_x_right  <= '0;
      r_y_up     <= '0;
      r_y_down   <= '0;
      r_active   <= '0;
      r_overflow <= 1'b0;
      r_passed   <= '0;
      r_lfsr     <= LFSR_SEED;
      r_cnt      <= CNT_W'(SPAWN_INTERVAL - 1);
`ifdef OBSTACLE_DIFFICULTY_RAMP_EN
      r_frame    <= '0;
      r_speed    <= 4'(SCROLL_SPEED);
      r_interval <= CNT_W'(SPAWN_INTERVAL);
`endif
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      case (r_state)
        S_CLEAR: begin
          r_x_left   <= '0;
          r_x_right  <= '0;
          r_y_up     <= '0;
          r_y_down   <= '0;
          r_active   <= '0;
          r_overflow <= 1'b0;
          r_passed   <= '0;
          r_cnt      <= CNT_W'(SPAWN_INTERVAL - 1);
`ifdef OBSTACLE_DIFFICULTY_RAMP_EN
          r_frame    <= '0;
          r_speed    <= 4'(SCROLL_SPEED);
          r_interval <= CNT_W'(SPAWN_INTERVAL);
`endif
        end
        S_RUN: begin
          for (int i = 0; i < SLOTS; i++) begin
            if (w_retire[i]) begin
              r_x_left[i]  <= '0;
              r_x_right[i] <= '0;
              r_y_up[i]    <= '0;
              r_y_down[i]  <= '0;
              r_active[i]  <= 1'b0;
            end else if (r_active[i]) begin
              r_x_left[i]  <= r_x_left[i] - {6'd0, w_speed};
              r_x_right[i] <= r_x_right[i] - {6'd0, w_speed};
            end else if (w_spawn_sel[i]) begin
              r_x_left[i]  <= 10'(SCREEN_W);
              r_x_right[i] <= 10'(SCREEN_W + OBS_W);
              r_y_up[i]    <= w_y_up;
              r_y_down[i]  <= w_y_up + 9'(OBS_H);
              r_active[i]  <= 1'b1;
            end
          end
          if (w_spawn_due) begin
            r_cnt <= w_reload;
            if (!w_free_found) r_overflow <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
          r_passed <= w_passed_sum[16] ? 16'hFFFF : w_passed_sum[15:0];
`ifdef OBSTACLE_DIFFICULTY_RAMP_EN
          if (r_frame == 10'd599) begin
            r_frame    <= '0;
            r_speed    <= (r_speed < 4'd8) ? r_speed + 4'd1 : r_speed;
            r_interval <= (r_interval >= CNT_W'(40)) ? r_interval - CNT_W'(10) : CNT_W'(30);
          end else begin
            r_frame <= r_frame + 10'd1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign o_obstacle_x_left  = r_x_left;
  assign o_obstacle_x_right = r_x_right;
  assign o_obstacle_y_up    = r_y_up;
  assign o_obstacle_y_down  = r_y_down;
  assign o_active           = r_active;
  assign o_spawn_overflow   = r_overflow;
  assign o_passed_count     = r_passed;

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
- Frame-rate controller that owns the 10 obstacle slots consumed by game_logic's collision check and by the renderer.
- Spawns obstacles into free slots on a programmable interval, with pseudo-random vertical placement from an LFSR.
- Scrolls active obstacles left each frame, retires them at the left edge, and counts obstacles passed.
- Sequenced by gamemode: clear, run, freeze.

Parameters:
- SLOTS, 10, obstacle slot count; matches game_logic's array depth.
- SCREEN_W, 640, spawn x_left.
- OBS_W, 40, obstacle width in pixels.
- OBS_H, 120, obstacle height in pixels.
- UPPER_BOUND, 20, top of playfield.
- LOWER_BOUND, 460, bottom of playfield.
- SPAWN_INTERVAL, 90, frames between spawns.
- SCROLL_SPEED, 4, pixels per frame leftward.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  60 Hz frame clock.
- rst  in  1  synchronous, active-high reset.
- gamemode  in  2  00 clear, 01 run, 10 pause, 11 game over.
- obstacle_x_left  out  [9:0][9:0]  per-slot left x.
- obstacle_x_right  out  [9:0][9:0]  per-slot right x.
- obstacle_y_up  out  [9:0][8:0]  per-slot top y.
- obstacle_y_down  out  [9:0][8:0]  per-slot bottom y.
- active  out  10  per-slot valid mask.
- spawn_overflow  out  1  sticky; a spawn was dropped because no slot was free.
- passed_count  out  16  obstacles retired, saturating.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - All coordinates 0, active 0.
  - spawn_overflow 0, passed_count 0.
  - LFSR = LFSR_SEED, spawn counter = SPAWN_INTERVAL-1.
  - State = CLEAR.
- Inactive-slot encoding: an inactive slot always drives x_left = x_right = y_up = y_down = 0. This guarantees no AABB hit against the player at x 160..200.
- States (registered), one per gamemode value:
  - CLEAR (00): every cycle, clear all slots, spawn_overflow and passed_count; reload spawn counter to SPAWN_INTERVAL-1.
  - RUN (01): scroll, retire and spawn, as below.
  - PAUSE (10) and OVER (11): all slot state and counters hold.
  - Transitions follow gamemode every cycle. Leaving PAUSE or OVER for RUN resumes the spawn counter from its held value.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every non-reset cycle in all states, so placement depends on player timing.
- RUN, per cycle, all decisions taken from pre-update registered values:
  - Retire: an active slot with x_right <= SCROLL_SPEED is cleared to 0 / inactive. passed_count += number retired that cycle, saturating at 65535.
  - Scroll: any other active slot gets x_left -= SCROLL_SPEED and x_right -= SCROLL_SPEED.
  - Spawn counter: if the counter is 0, spawn and reload SPAWN_INTERVAL-1; otherwise decrement. The first spawn after CLEAR therefore lands on the SPAWN_INTERVAL-th RUN cycle.
  - Spawn target: the lowest-index slot whose registered active bit is 0. A slot retiring this cycle is not reusable until the next cycle.
  - If no slot is free, the spawn is dropped and spawn_overflow is set to 1; the counter still reloads.
- Spawned slot values:
  - x_left = SCREEN_W, x_right = SCREEN_W+OBS_W (680; fits 10 bits).
  - r = lfsr[8:0]; if r >= R, r -= R, where R = LOWER_BOUND-UPPER_BOUND-OBS_H = 320.
  - y_up = UPPER_BOUND+r, y_down = y_up+OBS_H (<= 460).
  - A slot is not scrolled in its spawn cycle.
- Latency: outputs are registered and change on the cycle after the decision.
- Reset mid-operation: rst overrides all logic in the same cycle.

Optional Feature:
- Macro: OBSTACLE_DIFFICULTY_RAMP_EN.
- When defined:
  - A 10-bit frame counter runs in RUN only.
  - Every 600 RUN frames, the live scroll speed increments by 1 (starting at SCROLL_SPEED, max 8).
  - In the same event, the live spawn interval decreases by 10 (starting at SPAWN_INTERVAL, min 30).
  - Retire and spawn use the live values.
  - CLEAR restores both live values.
- When undefined: scroll speed and interval stay fixed at their parameters, and no ramp registers exist.

Test Plan:
- Reset: assert rst with gamemode 01 -> all outputs 0, active 0; a slot populates only on the 90th subsequent RUN cycle.
- Single spawn/scroll: after the first spawn, slot 0 shows x_left 640, x_right 680, 20 <= y_up <= 340, and y_down - y_up = 120. After 10 more RUN cycles x_left = 600. Retirement occurs when x_right <= 4; passed_count then = 1.
- Pause: gamemode 10 for 50 cycles -> all coordinates, the counter and active hold. Returning to 01 resumes the exact scroll and spawn schedule.
- Overflow: SPAWN_INTERVAL = 2 -> slots 0..9 fill in index order. The 11th spawn is dropped and spawn_overflow = 1, staying 1 until gamemode 00.
- Clear: gamemode 00 for one cycle with 5 active slots -> active = 0, passed_count = 0, spawn_overflow = 0.
- Ramp (OBSTACLE_DIFFICULTY_RAMP_EN defined): after 600 RUN frames, per-frame x decrement = 5 and spawn spacing = 80 frames.
